// File: rtl/mips_wb_pkg.sv
// Shared types and defaults for the register-file write-back unit.
package mips_wb_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int LQ_DEPTH_DEF = 4;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // One outstanding-load slot: destination register, returned data, data-arrived flag
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
    logic                  dvalid;
  } lq_entry_t;

endpackage

// File: rtl/mips_wb_load_queue.sv
// In-order outstanding-load queue with head/tail/fill pointers and per-register pending decode.
// Pointers carry one extra wrap bit so a queue whose every entry still awaits data
// (fill == head, tail == head + depth) is distinguished from an empty fill window.
module mips_wb_load_queue
  import mips_wb_pkg::*;
#(
  parameter int LQ_DEPTH = LQ_DEPTH_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              pop,
  output logic              ld_ready,
  output logic              head_valid,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              push_err,
  output logic              fill_err,
  output logic [31:0]       pending
);

  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] PTR_FULL = (PTR_W+1)'(LQ_DEPTH);

  logic [ADDR_W-1:0]   addr_q [LQ_DEPTH];
  logic [DATA_W-1:0]   data_q [LQ_DEPTH];
  logic [LQ_DEPTH-1:0] dvalid_q;

  logic [PTR_W:0] head_p, tail_p, fill_p, count;
  logic           push_ok, fill_ok, pop_ok;

  assign count      = tail_p - head_p;
  assign ld_ready   = (count != PTR_FULL);
  assign head_valid = (count != '0) && dvalid_q[head_p[PTR_W-1:0]];
  assign head_addr  = addr_q[head_p[PTR_W-1:0]];
  assign head_data  = data_q[head_p[PTR_W-1:0]];

  assign push_ok  = push && ld_ready;
  assign fill_ok  = fill && (fill_p != tail_p);
  assign pop_ok   = pop && head_valid;
  assign push_err = push && !ld_ready;
  assign fill_err = fill && (fill_p == tail_p);

  // Allocate at tail, deposit returning data at fill, retire at head; all three may happen together
  always_ff @(posedge clk) begin
    if (rst) begin
      head_p   <= '0;
      tail_p   <= '0;
      fill_p   <= '0;
      dvalid_q <= '0;
    end else begin
      if (push_ok) begin
        addr_q[tail_p[PTR_W-1:0]]   <= push_addr;
        dvalid_q[tail_p[PTR_W-1:0]] <= 1'b0;
        tail_p                      <= tail_p + PTR_ONE;
      end
      if (fill_ok) begin
        data_q[fill_p[PTR_W-1:0]]   <= fill_data;
        dvalid_q[fill_p[PTR_W-1:0]] <= 1'b1;
        fill_p                      <= fill_p + PTR_ONE;
      end
      if (pop_ok) begin
        head_p <= head_p + PTR_ONE;
      end
    end
  end

  // Mark the destination register of every occupied slot as having a write in flight
  always_comb begin
    logic [PTR_W-1:0] offset;
    pending = '0;
    offset  = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      offset = PTR_W'(i) - head_p[PTR_W-1:0];
      if ({1'b0, offset} < count) begin
        pending[addr_q[i]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mips_wb_unit.sv
// Register-file write-back initiator: arbitrates ALU results (priority) against
// in-order load returns and drives one registered write per cycle.
module mips_wb_unit
  import mips_wb_pkg::*;
#(
  parameter int LQ_DEPTH = LQ_DEPTH_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_issue,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_ready,
  input  logic              mem_readdatavalid,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              reg_write,
  output logic [ADDR_W-1:0] reg_write_addr,
  output logic [DATA_W-1:0] reg_write_data,
  output logic [31:0]       pending,
  output logic              err
);

  logic              head_valid;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              push_err, fill_err, waw_err;
  logic [31:0]       lq_pending;

  mips_wb_load_queue #(
    .LQ_DEPTH (LQ_DEPTH),
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W)
  ) u_lq (
    .clk        (clk),
    .rst        (rst),
    .push       (ld_issue),
    .push_addr  (ld_addr),
    .fill       (mem_readdatavalid),
    .fill_data  (mem_readdata),
    .pop        (!alu_valid),
    .ld_ready   (ld_ready),
    .head_valid (head_valid),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .push_err   (push_err),
    .fill_err   (fill_err),
    .pending    (lq_pending)
  );

  // Queued loads plus the write currently presented to the register file; $0 never stalls
  always_comb begin
    pending = lq_pending;
    if (reg_write) begin
      pending[reg_write_addr] = 1'b1;
    end
    pending[0] = 1'b0;
  end

  assign waw_err = alu_valid && pending[alu_addr];

  // ALU wins the write port; otherwise a data-ready head load retires; writes to $0 are suppressed
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write      <= 1'b0;
      reg_write_addr <= '0;
      reg_write_data <= '0;
      err            <= 1'b0;
    end else begin
      if (alu_valid) begin
        reg_write      <= (alu_addr != ADDR_W'(REG_ZERO));
        reg_write_addr <= alu_addr;
        reg_write_data <= alu_data;
      end else if (head_valid) begin
        reg_write      <= (head_addr != ADDR_W'(REG_ZERO));
        reg_write_addr <= head_addr;
        reg_write_data <= head_data;
      end else begin
        reg_write <= 1'b0;
      end
      if (push_err || fill_err || waw_err) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mips_wb_unit.sv
// Self-checking bench for mips_wb_unit: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based reference model.
module tb_mips_wb_unit;
  import mips_wb_pkg::*;

  localparam int LQ = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_addr = '0;
  logic [31:0] alu_data = '0;
  logic        ld_issue = 1'b0;
  logic [4:0]  ld_addr = '0;
  logic        ld_ready;
  logic        mem_readdatavalid = 1'b0;
  logic [31:0] mem_readdata = '0;
  logic        reg_write;
  logic [4:0]  reg_write_addr;
  logic [31:0] reg_write_data;
  logic [31:0] pending;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  mips_wb_unit #(.LQ_DEPTH(LQ), .DATA_W(32), .ADDR_W(5)) dut (
    .clk               (clk),
    .rst               (rst),
    .alu_valid         (alu_valid),
    .alu_addr          (alu_addr),
    .alu_data          (alu_data),
    .ld_issue          (ld_issue),
    .ld_addr           (ld_addr),
    .ld_ready          (ld_ready),
    .mem_readdatavalid (mem_readdatavalid),
    .mem_readdata      (mem_readdata),
    .reg_write         (reg_write),
    .reg_write_addr    (reg_write_addr),
    .reg_write_data    (reg_write_data),
    .pending           (pending),
    .err               (err)
  );

  always #5 clk = ~clk;

  // Reference model: outstanding loads in issue order, plus the presented write
  lq_entry_t   m_q[$];
  logic        m_rw = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic        m_err = 1'b0;

  function automatic logic [31:0] model_pending();
    logic [31:0] p;
    p = '0;
    foreach (m_q[i]) p[m_q[i].addr] = 1'b1;
    if (m_rw) p[m_addr] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  function automatic int model_unfilled();
    int n;
    n = 0;
    foreach (m_q[i]) if (!m_q[i].dvalid) n++;
    return n;
  endfunction

  // Advance the model on each rising edge using the inputs the DUT samples there
  always @(posedge clk) begin : model_step
    logic [31:0] p;
    logic        head_rdy;
    logic        full;
    int          fi;
    lq_entry_t   e;
    if (rst) begin
      m_q.delete();
      m_rw = 1'b0; m_addr = '0; m_data = '0; m_err = 1'b0;
    end else begin
      p        = model_pending();
      full     = (m_q.size() == LQ);
      head_rdy = (m_q.size() > 0) && m_q[0].dvalid;
      fi = -1;
      foreach (m_q[i]) if (!m_q[i].dvalid && fi < 0) fi = i;
      if (ld_issue && full) m_err = 1'b1;
      if (mem_readdatavalid && fi < 0) m_err = 1'b1;
      if (alu_valid && p[alu_addr]) m_err = 1'b1;
      if (mem_readdatavalid && fi >= 0) begin
        e = m_q[fi]; e.data = mem_readdata; e.dvalid = 1'b1; m_q[fi] = e;
      end
      if (alu_valid) begin
        m_rw = (alu_addr != 5'd0); m_addr = alu_addr; m_data = alu_data;
      end else if (head_rdy) begin
        e = m_q.pop_front();
        m_rw = (e.addr != 5'd0); m_addr = e.addr; m_data = e.data;
      end else begin
        m_rw = 1'b0;
      end
      if (ld_issue && !full) begin
        e.addr = ld_addr; e.data = '0; e.dvalid = 1'b0;
        m_q.push_back(e);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("model.reg_write", 32'(reg_write), 32'(m_rw));
      if (m_rw) begin
        checkOutput("model.addr", 32'(reg_write_addr), 32'(m_addr));
        checkOutput("model.data", reg_write_data, m_data);
      end
      checkOutput("model.ld_ready", 32'(ld_ready), 32'(m_q.size() != LQ));
      checkOutput("model.pending", pending, model_pending());
      checkOutput("model.err", 32'(err), 32'(m_err));
    end
  end

  // Drive one cycle of inputs, then return just after the edge that sampled them
  task automatic applyStimulus(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                               input logic li, input logic [4:0] la,
                               input logic rv, input logic [31:0] rd, input logic r);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    ld_issue = li; ld_addr = la;
    mem_readdatavalid = rv; mem_readdata = rd;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b1);
    idle();
  endtask

  task automatic issueLoad(input logic [4:0] a);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, a, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic respond(input logic [31:0] d);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, d, 1'b0);
  endtask

  initial begin
    // Reset state
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b1);
    chk_en = 1'b1;
    checkOutput("rst.reg_write", 32'(reg_write), 32'd0);
    checkOutput("rst.addr", 32'(reg_write_addr), 32'd0);
    checkOutput("rst.data", reg_write_data, 32'd0);
    checkOutput("rst.pending", pending, 32'd0);
    checkOutput("rst.ld_ready", 32'(ld_ready), 32'd1);
    checkOutput("rst.err", 32'(err), 32'd0);

    // ALU write, one-cycle latency
    idle();
    applyStimulus(1'b1, 5'd8, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("alu.reg_write", 32'(reg_write), 32'd1);
    checkOutput("alu.addr", 32'(reg_write_addr), 32'd8);
    checkOutput("alu.data", reg_write_data, 32'hDEADBEEF);
    checkOutput("alu.pending", pending, 32'h0000_0100);
    idle();
    checkOutput("alu.after", 32'(reg_write), 32'd0);
    checkOutput("alu.pending_clr", pending, 32'd0);

    // Load path: response to write is two cycles
    issueLoad(5'd2);
    checkOutput("ld.pending", pending, 32'h0000_0004);
    idle(); idle(); idle();
    respond(32'h1234);
    checkOutput("ld.no_bypass", 32'(reg_write), 32'd0);
    idle();
    checkOutput("ld.reg_write", 32'(reg_write), 32'd1);
    checkOutput("ld.addr", 32'(reg_write_addr), 32'd2);
    checkOutput("ld.data", reg_write_data, 32'h1234);
    checkOutput("ld.pending_hold", pending, 32'h0000_0004);
    idle();
    checkOutput("ld.pending_clr", pending, 32'd0);

    // ALU priority over a ready load; back-to-back ALU to $9 trips the WAW check
    issueLoad(5'd10);
    respond(32'h55);
    applyStimulus(1'b1, 5'd9, 32'd1, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("conf.alu1", 32'(reg_write_addr), 32'd9);
    checkOutput("conf.alu1_data", reg_write_data, 32'd1);
    applyStimulus(1'b1, 5'd9, 32'd2, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("conf.alu2_data", reg_write_data, 32'd2);
    idle();
    checkOutput("conf.load_addr", 32'(reg_write_addr), 32'd10);
    checkOutput("conf.load_data", reg_write_data, 32'h55);
    checkOutput("conf.waw_err", 32'(err), 32'd1);

    // Full queue, overflow, ordering, pointer wrap
    doReset();
    for (int k = 0; k < 4; k++) issueLoad(5'(3 + k));
    checkOutput("full.ld_ready", 32'(ld_ready), 32'd0);
    checkOutput("full.pending", pending, 32'h0000_0078);
    issueLoad(5'd7);
    checkOutput("full.ovf_err", 32'(err), 32'd1);
    checkOutput("full.unchanged", pending, 32'h0000_0078);
    for (int k = 0; k < 4; k++) begin
      respond(32'd100 + 32'(k));
      if (k >= 1) checkOutput("full.order", 32'(reg_write_addr), 32'(3 + k - 1));
    end
    idle();
    checkOutput("full.last_addr", 32'(reg_write_addr), 32'd6);
    checkOutput("full.last_data", reg_write_data, 32'd103);
    for (int k = 0; k < 4; k++) issueLoad(5'(12 + k));
    for (int k = 0; k < 4; k++) begin
      respond(32'd200 + 32'(k));
      if (k >= 1) checkOutput("wrap.order", 32'(reg_write_addr), 32'(12 + k - 1));
    end
    idle();
    checkOutput("wrap.last_addr", 32'(reg_write_addr), 32'd15);
    checkOutput("wrap.last_data", reg_write_data, 32'd203);

    // Load to $0 pops silently; a response with nothing outstanding flags err
    doReset();
    issueLoad(5'd0);
    checkOutput("zero.pending", pending, 32'd0);
    respond(32'h77);
    idle();
    checkOutput("zero.no_write", 32'(reg_write), 32'd0);
    idle();
    checkOutput("zero.err_before", 32'(err), 32'd0);
    respond(32'h88);
    checkOutput("spur.err", 32'(err), 32'd1);
    checkOutput("spur.no_write", 32'(reg_write), 32'd0);

    // Reset with loads in flight; the late response is spurious
    doReset();
    issueLoad(5'd20);
    issueLoad(5'd21);
    checkOutput("mid.pending", pending, 32'h0030_0000);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b1);
    checkOutput("mid.ld_ready", 32'(ld_ready), 32'd1);
    checkOutput("mid.pending", pending, 32'd0);
    checkOutput("mid.reg_write", 32'(reg_write), 32'd0);
    checkOutput("mid.err", 32'(err), 32'd0);
    respond(32'h99);
    checkOutput("mid.late_err", 32'(err), 32'd1);

    // Randomized traffic, mostly legal with occasional violations and resets
    doReset();
    for (int c = 0; c < 3000; c++) begin
      logic        av, li, rv, r;
      logic [4:0]  aa, la;
      logic [31:0] ad, rd;
      r  = ($urandom_range(0, 199) == 0);
      li = ($urandom_range(0, 99) < 40) && ((m_q.size() < LQ) || ($urandom_range(0, 19) == 0));
      la = 5'($urandom_range(0, 31));
      rv = (model_unfilled() > 0) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 59) == 0);
      rd = $urandom;
      av = ($urandom_range(0, 99) < 35);
      aa = 5'($urandom_range(0, 31));
      ad = $urandom;
      if (av && model_pending()[aa] && ($urandom_range(0, 9) != 0)) av = 1'b0;
      applyStimulus(av, aa, ad, li, la, rv, rd, r);
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
